// File: rtl/count_event_monitor.sv
// Watches the upstream 3-bit saturating count, classifies each change and
// queues 5-bit event records for the logger; illegal behaviour latches a fault.
module count_event_monitor #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [2:0] count_in,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [4:0] evt_data,
  output logic [1:0] state,
  output logic       fault,
  output logic       overflow,
  output logic [7:0] drop_cnt
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'b00,
    S_COUNTING  = 2'b01,
    S_SATURATED = 2'b10,
    S_FAULT     = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    C_INC = 2'b00,
    C_SAT = 2'b01,
    C_CLR = 2'b10,
    C_ILL = 2'b11
  } code_t;

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  state_t        st_q, st_d;
  logic [2:0]    prev_q;
  logic          ev;
  code_t         code;

  logic [4:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          full, push_req, push, pop, drop;

  // Widen before the +1 so a stale prev_q of 7 cannot wrap into a fake INC.
  always_comb begin
    ev   = 1'b0;
    code = C_ILL;
    if (count_in != prev_q) begin
      ev = 1'b1;
      if (count_in > 3'd3)
        code = C_ILL;
      else if (count_in == 3'd3 && prev_q == 3'd2)
        code = C_SAT;
      else if ({1'b0, count_in} == {1'b0, prev_q} + 4'd1)
        code = C_INC;
      else if (count_in == 3'd0)
        code = C_CLR;
      else
        code = C_ILL;
    end
  end

  always_comb begin
    st_d = st_q;
    if (st_q != S_FAULT) begin
      if (ev && code == C_ILL)
        st_d = S_FAULT;
      else if (count_in == 3'd0)
        st_d = S_IDLE;
      else if (count_in == 3'd3)
        st_d = S_SATURATED;
      else
        st_d = S_COUNTING;
    end
  end

  assign full      = (cnt == (AW+1)'(FIFO_DEPTH));
  assign evt_valid = (cnt != '0);
  assign pop       = evt_valid && evt_ready;
  assign push_req  = ev && (st_q != S_FAULT);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push      = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;
  assign evt_data  = evt_valid ? mem[rd_ptr] : '0;
  assign state     = st_q;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {code, count_in};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_q     <= S_IDLE;
      prev_q   <= '0;
      fault    <= 1'b0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
    end else begin
      st_q   <= st_d;
      prev_q <= count_in;
      fault  <= (st_d == S_FAULT);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1)
          drop_cnt <= drop_cnt + 8'd1;
      end
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
